// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router state encoding, port addresses and helpers
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_t;

    localparam logic [1:0] PORT0   = 2'd0;
    localparam logic [1:0] PORT1   = 2'd1;
    localparam logic [1:0] PORT2   = 2'd2;
    localparam logic [1:0] INVALID = 2'd3;

    // Picks the per-port flag addressed by sel; the unused INVALID address reads as 0.
    function automatic logic port_flag(input logic [1:0] sel, input logic f0,
                                       input logic f1, input logic f2);
        logic r;
        case (sel)
            PORT0:   r = f0;
            PORT1:   r = f1;
            PORT2:   r = f2;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_ctrl.sv
// rtl/router_fsm_ctrl.sv - router packet-load controller FSM with latched destination address
module router_fsm_ctrl
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    router_state_t state;
    router_state_t state_next;
    logic [1:0]    addr;

    logic empty_live;
    logic empty_addr;
    logic soft_reset_addr;

    // Header decode looks at the live bus; later states only trust the latched address.
    assign empty_live      = port_flag(data_in, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    assign empty_addr      = port_flag(addr, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    assign soft_reset_addr = port_flag(addr, soft_reset_0, soft_reset_1, soft_reset_2);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
            addr  <= PORT0;
        end else begin
            state <= state_next;
            if (state == DECODE_ADDRESS && pkt_valid) begin
                addr <= data_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != INVALID) begin
                    state_next = empty_live ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_next = LOAD_PARITY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_addr) begin
                    state_next = LOAD_FIRST_DATA;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_next = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_next = LOAD_PARITY;
                end else begin
                    state_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_next = DECODE_ADDRESS;
        endcase

        // A read timeout on the selected port abandons the packet from any active state.
        if (state != DECODE_ADDRESS && soft_reset_addr) begin
            state_next = DECODE_ADDRESS;
        end
    end

    assign detect_addr   = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL)
                         || (state == LOAD_PARITY);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// tb/tb_router_fsm_ctrl.sv - table-driven checks of the router controller FSM
module tb_router_fsm_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy;

    always #5 clk = ~clk;

    router_fsm_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_addr   (detect_addr),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy)
    );

    // Expected output word {detect,lfd,ld,laf,full,rst_int,wen,busy} per state
    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_LFD = 8'b0100_0001;
    localparam logic [7:0] E_LD  = 8'b0010_0010;
    localparam logic [7:0] E_LAF = 8'b0001_0011;
    localparam logic [7:0] E_FUL = 8'b0000_1001;
    localparam logic [7:0] E_CPE = 8'b0000_0101;
    localparam logic [7:0] E_LP  = 8'b0000_0011;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    typedef struct {
        logic       rstn;
        logic       pv;
        logic [1:0] di;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rstn, input logic pv, input logic [1:0] di,
                                input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                                input logic pd, input logic lpv, input logic [7:0] exp);
        vec_t v;
        v.rstn = rstn; v.pv = pv; v.di = di; v.ff = ff; v.fe = fe;
        v.sr = sr; v.pd = pd; v.lpv = lpv; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [7:0] got;
        resetn        = v.rstn;
        pkt_valid     = v.pv;
        data_in       = v.di;
        fifo_full     = v.ff;
        fifo_empty_0  = v.fe[0];
        fifo_empty_1  = v.fe[1];
        fifo_empty_2  = v.fe[2];
        soft_reset_0  = v.sr[0];
        soft_reset_1  = v.sr[1];
        soft_reset_2  = v.sr[2];
        parity_done   = v.pd;
        low_pkt_valid = v.lpv;
        @(negedge clk);
        got = {detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy};
        n_vec++;
        if (got !== v.exp) begin
            n_bad++;
            $display("FAIL %s: outputs %b, expected %b", name, got, v.exp);
        end
    endtask

    initial begin
        // rstn pv di ff fe sr pd lpv exp
        tbl.push_back(mk(0, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, E_DA));   // reset
        tbl.push_back(mk(1, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LFD));  // hdr port1 empty
        tbl.push_back(mk(1, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LD));
        tbl.push_back(mk(1, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LD));   // stay loading
        tbl.push_back(mk(1, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LP));
        tbl.push_back(mk(1, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_CPE));
        tbl.push_back(mk(1, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_DA));
        tbl.push_back(mk(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LFD));  // hdr port0
        tbl.push_back(mk(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LD));
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FUL));  // full beats !pv
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FUL));
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FUL));
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LAF));
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b001, 3'b000, 0, 1, E_LP));   // low_pkt_valid
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_CPE));
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FUL));  // CPE while full
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LAF));
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b001, 3'b000, 1, 1, E_DA));   // parity_done wins
        tbl.push_back(mk(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LFD));
        tbl.push_back(mk(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LD));
        tbl.push_back(mk(1, 1, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FUL));
        tbl.push_back(mk(1, 1, 2'd0, 1, 3'b001, 3'b010, 0, 0, E_FUL));  // sr1 ignored
        tbl.push_back(mk(1, 1, 2'd0, 1, 3'b001, 3'b100, 0, 0, E_FUL));  // sr2 ignored
        tbl.push_back(mk(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LAF));
        tbl.push_back(mk(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LD));   // LAF -> LD
        tbl.push_back(mk(1, 1, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FUL));
        tbl.push_back(mk(1, 1, 2'd0, 1, 3'b001, 3'b001, 0, 0, E_DA));   // sr0 aborts
        tbl.push_back(mk(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, E_DA));   // invalid address
        tbl.push_back(mk(1, 1, 2'd3, 0, 3'b111, 3'b111, 0, 0, E_DA));
        tbl.push_back(mk(1, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, E_LFD));
        tbl.push_back(mk(1, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, E_LD));
        tbl.push_back(mk(0, 1, 2'd2, 1, 3'b100, 3'b100, 1, 1, E_DA));   // reset mid-packet
        tbl.push_back(mk(1, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, E_LFD));
        tbl.push_back(mk(1, 1, 2'd2, 0, 3'b100, 3'b100, 0, 0, E_DA));   // sr in LFD

        @(negedge clk);
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Wait-till-empty must track the latched port, not the live bus
        apply(mk(1, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, E_WTE), "wte_enter");
        for (int k = 0; k < 5; k++)
            apply(mk(1, 1, 2'd0, 0, 3'b001, 3'b011, 0, 0, E_WTE), $sformatf("wte_hold%0d", k));
        apply(mk(1, 1, 2'd0, 0, 3'b101, 3'b000, 0, 0, E_LFD), "wte_to_lfd");
        apply(mk(1, 1, 2'd0, 0, 3'b101, 3'b000, 0, 0, E_LD), "wte_ld");
        apply(mk(1, 0, 2'd0, 0, 3'b000, 3'b001, 0, 0, E_LP), "addr2_kept");
        apply(mk(1, 0, 2'd0, 0, 3'b000, 3'b100, 0, 0, E_DA), "sr2_in_lp");

        // Soft reset on the selected port while waiting
        apply(mk(1, 1, 2'd1, 0, 3'b000, 3'b000, 0, 0, E_WTE), "wte1_enter");
        apply(mk(1, 0, 2'd1, 0, 3'b000, 3'b010, 0, 0, E_DA), "wte1_sr1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
